// File: rtl/lanes_tx_scheduler.sv
// Dual-lane transmit word scheduler: buffers lane-pair words and presents one word
// per lane at word boundaries set by the latched link speed, filling on underrun.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | serializer off, speed not latched, outputs hold last word
// START | one cycle: load FIFO head (or fill word) for the first period
// RUN   | serializer on, new word at every boundary, tx_en low -> DRAIN
// DRAIN | serializer on, no new input, exit to IDLE at empty boundary
module lanes_tx_scheduler #(
  parameter int unsigned      WIDTH      = 132,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] FILL_WORD  = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tx_en_i,
  input  logic [1:0]       gen_speed_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_lane_0_data_i,
  input  logic [WIDTH-1:0] in_lane_1_data_i,
  output logic             enable_ser_o,
  output logic [WIDTH-1:0] lane_0_tx_parallel_o,
  output logic [WIDTH-1:0] lane_1_tx_parallel_o,
  output logic             word_load_o,
  output logic             underrun_o,
  output logic [15:0]      underrun_cnt_o,
  output logic             busy_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [1:0]         speed_q, speed_d;
  logic [7:0]         bit_cnt_q, bit_cnt_d;
  logic               enable_q, enable_d;
  logic [WIDTH-1:0]   lane0_q, lane0_d;
  logic [WIDTH-1:0]   lane1_q, lane1_d;
  logic               word_load_q, word_load_d;
  logic               underrun_q, underrun_d;
  logic [15:0]        ucnt_q, ucnt_d;

  logic               push;
  logic               pop;
  logic               load;
  logic               fifo_empty;
  logic               boundary;
  logic [7:0]         period;
  logic [2*WIDTH-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign period     = (speed_q == 2'b00) ? 8'd66 : 8'd132;
  assign boundary   = (bit_cnt_q == (period - 8'd1));

  // Ready comes from registered count only; a same-cycle pop never frees a slot.
  assign in_ready_o = (count_q < CW'(FIFO_DEPTH)) && (state_q != ST_DRAIN);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = load && !fifo_empty;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (tx_en_i) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (!tx_en_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (tx_en_i)                      state_d = ST_RUN;
        else if (boundary && fifo_empty)  state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath next values
  always_comb begin
    load      = 1'b0;
    bit_cnt_d = 8'd0;
    speed_d   = speed_q;
    ucnt_d    = ucnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_en_i) begin
          speed_d = gen_speed_i;
          ucnt_d  = 16'd0;
        end
      end
      ST_START: load = 1'b1;
      ST_RUN: begin
        load      = boundary;
        bit_cnt_d = boundary ? 8'd0 : bit_cnt_q + 8'd1;
      end
      ST_DRAIN: begin
        // The final empty boundary ends the burst without sending a fill word.
        load      = boundary && (!fifo_empty || tx_en_i);
        bit_cnt_d = boundary ? 8'd0 : bit_cnt_q + 8'd1;
      end
      default: ;
    endcase

    enable_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    word_load_d = load;
    underrun_d  = load && fifo_empty;
    lane0_d     = lane0_q;
    lane1_d     = lane1_q;
    if (load) begin
      lane0_d = fifo_empty ? FILL_WORD : head[WIDTH-1:0];
      lane1_d = fifo_empty ? FILL_WORD : head[2*WIDTH-1:WIDTH];
      if (fifo_empty && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {in_lane_1_data_i, in_lane_0_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      speed_q     <= 2'b00;
      bit_cnt_q   <= 8'd0;
      enable_q    <= 1'b0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      word_load_q <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      speed_q     <= speed_d;
      bit_cnt_q   <= bit_cnt_d;
      enable_q    <= enable_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      word_load_q <= word_load_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign enable_ser_o         = enable_q;
  assign lane_0_tx_parallel_o = lane0_q;
  assign lane_1_tx_parallel_o = lane1_q;
  assign word_load_o          = word_load_q;
  assign underrun_o           = underrun_q;
  assign underrun_cnt_o       = ucnt_q;
  assign busy_o               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lanes_tx_scheduler.sv
// Directed bench for lanes_tx_scheduler: expected lane words are queued as they are
// pushed (fill words queued where an underrun is intended) and popped at each word_load.
module tb_lanes_tx_scheduler;
  localparam int W = 132;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          tx_en_i;
  logic [1:0]    gen_speed_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_lane_0_data_i;
  logic [W-1:0]  in_lane_1_data_i;
  logic          enable_ser_o;
  logic [W-1:0]  lane_0_tx_parallel_o;
  logic [W-1:0]  lane_1_tx_parallel_o;
  logic          word_load_o;
  logic          underrun_o;
  logic [15:0]   underrun_cnt_o;
  logic          busy_o;

  lanes_tx_scheduler #(.WIDTH(W), .FIFO_DEPTH(4), .FILL_WORD({W{1'b0}})) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tx_en_i(tx_en_i), .gen_speed_i(gen_speed_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_lane_0_data_i(in_lane_0_data_i), .in_lane_1_data_i(in_lane_1_data_i),
    .enable_ser_o(enable_ser_o), .lane_0_tx_parallel_o(lane_0_tx_parallel_o),
    .lane_1_tx_parallel_o(lane_1_tx_parallel_o), .word_load_o(word_load_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           fill;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_ucnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] mkword(input int tag);
    logic [3:0] t4;
    t4 = tag[3:0];
    return {$urandom(), $urandom(), $urandom(), $urandom(), t4};
  endfunction

  task automatic push_pair(input int tag, output bit acc);
    logic [W-1:0] a, b;
    a = mkword(tag);
    b = mkword(tag + 8);
    acc = in_ready_o;
    in_valid_i = 1'b1;
    in_lane_0_data_i = a;
    in_lane_1_data_i = b;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    if (acc) exp_q.push_back('{a: a, b: b, fill: 1'b0});
  endtask

  task automatic queue_fill();
    exp_q.push_back('{a: {W{1'b0}}, b: {W{1'b0}}, fill: 1'b1});
  endtask

  task automatic check_load();
    exp_t e;
    check("exp_avail", W'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.fill) exp_ucnt++;
      check("lane0_word", lane_0_tx_parallel_o, e.a);
      check("lane1_word", lane_1_tx_parallel_o, e.b);
      check("underrun_pulse", W'(underrun_o), W'(e.fill));
      check("underrun_cnt", W'(underrun_cnt_o), W'(exp_ucnt));
      check("enable_at_load", W'(enable_ser_o), 1);
    end
  endtask

  task automatic wait_load(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (word_load_o) begin
        at = cyc;
        break;
      end
    end
    check("load_timeout", W'(at >= 0), 1);
    if (at >= 0) check_load();
  endtask

  task automatic drain_check(input int last_at, input int p);
    int at, nl;
    at = -1;
    nl = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (word_load_o) nl++;
      if (!busy_o) begin
        at = cyc;
        break;
      end
    end
    check("drain_timeout", W'(at >= 0), 1);
    check("drain_exit_cyc", W'(at), W'(last_at + p));
    check("drain_enable_low", W'(enable_ser_o), 0);
    check("drain_extra_loads", W'(nl), 0);
  endtask

  task automatic run_stream(input logic [1:0] spd, input int n, input int p, input bit toggle);
    int c, at;
    exp_ucnt = 0;
    gen_speed_i = spd;
    tx_en_i = 1'b1;
    c = cyc;
    at = 0;
    for (int k = 0; k < n; k++) begin
      wait_load(300, at);
      check("load_cyc", W'(at), W'(c + 2 + k * p));
      if (k == 0 && toggle) gen_speed_i = 2'b00;
      if (k == n - 1) tx_en_i = 1'b0;
    end
    drain_check(at, p);
  endtask

  initial begin
    bit acc;
    int nacc, c, at;
    rst_ni = 1'b0;
    tx_en_i = 1'b0;
    gen_speed_i = 2'b00;
    in_valid_i = 1'b0;
    in_lane_0_data_i = '0;
    in_lane_1_data_i = '0;

    // Reset values
    @(negedge clk_i);
    check("rst_enable", W'(enable_ser_o), 0);
    check("rst_lane0", lane_0_tx_parallel_o, 0);
    check("rst_lane1", lane_1_tx_parallel_o, 0);
    check("rst_word_load", W'(word_load_o), 0);
    check("rst_underrun", W'(underrun_o), 0);
    check("rst_ucnt", W'(underrun_cnt_o), 0);
    check("rst_busy", W'(busy_o), 0);
    check("rst_ready", W'(in_ready_o), 1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Gen3 stream, four prefilled pairs
    for (int i = 0; i < 4; i++) push_pair(i, acc);
    run_stream(2'b01, 4, 132, 1'b0);
    check("gen3_ucnt_end", W'(underrun_cnt_o), 0);

    // Gen2 period
    for (int i = 0; i < 4; i++) push_pair(4 + i, acc);
    run_stream(2'b00, 4, 66, 1'b0);

    // Underrun: one pair then two fill words
    push_pair(9, acc);
    queue_fill();
    queue_fill();
    run_stream(2'b01, 3, 132, 1'b0);

    // Drain with three entries queued, tx_en dropped mid-word
    for (int i = 0; i < 4; i++) push_pair(10 + i, acc);
    exp_ucnt = 0;
    gen_speed_i = 2'b01;
    tx_en_i = 1'b1;
    c = cyc;
    wait_load(300, at);
    check("drain_first_cyc", W'(at), W'(c + 2));
    repeat (10) @(negedge clk_i);
    tx_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("drain_ready_low", W'(in_ready_o), 0);
    push_pair(14, acc);
    check("drain_push_refused", W'(acc), 0);
    for (int k = 1; k <= 3; k++) begin
      wait_load(300, at);
      check("drain_load_cyc", W'(at), W'(c + 2 + k * 132));
    end
    drain_check(at, 132);

    // Full/backpressure then speed lock
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      push_pair(i, acc);
      if (acc) nacc++;
    end
    check("full_accepted", W'(nacc), 4);
    check("full_beat5_ready", W'(acc), 0);
    run_stream(2'b01, 4, 132, 1'b1);

    // Async reset mid-RUN
    for (int i = 0; i < 2; i++) push_pair(5 + i, acc);
    exp_ucnt = 0;
    gen_speed_i = 2'b01;
    tx_en_i = 1'b1;
    wait_load(300, at);
    repeat (20) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("arst_enable", W'(enable_ser_o), 0);
    check("arst_lane0", lane_0_tx_parallel_o, 0);
    check("arst_lane1", lane_1_tx_parallel_o, 0);
    check("arst_word_load", W'(word_load_o), 0);
    check("arst_underrun", W'(underrun_o), 0);
    check("arst_ucnt", W'(underrun_cnt_o), 0);
    check("arst_busy", W'(busy_o), 0);
    tx_en_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("arst_ready_after", W'(in_ready_o), 1);
    check("arst_busy_after", W'(busy_o), 0);
    push_pair(15, acc);
    run_stream(2'b01, 1, 132, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
